ysyx_25080199_ifu: RTL
======================

# ysyx_25080199_ifu

Instruction fetch unit for the single-issue TRM core, sitting directly upstream of decode/execute. Holds the architectural PC, issues one word-aligned instruction fetch at a time to instruction memory over a valid/ready request channel, and captures the response. It presents the fetched {pc, inst} pair downstream with a valid/ready handshake, and accepts redirects (jumps/branches) from execute.

## Interface
- `RESET_PC`, 32'h8000_0000, PC loaded on reset
- `clk` input 1, sole clock, rising edge
- `rst_n` input 1, reset, asynchronous assert, active-low
- `imem_req_valid` output 1, fetch request valid
- `imem_req_ready` input 1, memory accepts request
- `imem_req_addr` output 32, fetch address; always equals the current PC
- `imem_resp_valid` input 1, response valid; always accepted, no back-pressure
- `imem_resp_data` input 32, instruction word
- `redirect_valid` input 1, execute requests PC change
- `redirect_pc` input 32, new PC; bits [1:0] ignored and forced to 0
- `out_valid` output 1, fetched instruction available
- `out_ready` input 1, downstream accepts
- `out_pc` output 32, PC of the presented instruction
- `out_inst` output 32, presented instruction
- `fetch_cnt` output 32, count of instructions delivered downstream (out handshakes), wraps 32'hFFFF_FFFF→0

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: pc, inst_buf, drop, fetch_cnt.
- `imem_req_valid` = (state==REQ); `out_valid` = (state==HOLD); `out_pc` = pc; `out_inst` = inst_buf.
- IDLE: entered only by reset; unconditionally → REQ next cycle. `imem_resp_valid` ignored.
- REQ:
  - `redirect_valid` → pc ← redirect_pc&~3. An unaccepted request may change address on redirect.
  - req handshake without redirect → WAIT, drop=0.
  - req handshake with redirect in the same cycle → WAIT, drop=1. The in-flight old-PC fetch is discarded.
- WAIT:
  - `redirect_valid` → pc ← redirect_pc&~3, drop ← 1.
  - `imem_resp_valid` with drop=1, or with redirect in the same cycle → discard data, drop ← 0, → REQ.
  - `imem_resp_valid` otherwise → inst_buf ← imem_resp_data, → HOLD.
- HOLD:
  - `redirect_valid` has priority over `out_ready`: pc ← redirect_pc&~3, → REQ. The instruction is flushed, not delivered, and fetch_cnt is unchanged.
  - `out_ready` otherwise → pc ← pc+4 (mod 2^32), fetch_cnt+1, → REQ.
- `imem_resp_valid` in REQ/HOLD/IDLE is a protocol violation by memory and is ignored.
- At most one fetch outstanding at any time.

## Timing
- Reset (async, `rst_n`=0):
  - state=IDLE, pc=RESET_PC, inst_buf=0, drop=0, fetch_cnt=0.
  - Outputs: `imem_req_valid`=0, `out_valid`=0, `out_pc`=RESET_PC, `out_inst`=0, `fetch_cnt`=0.
- First `imem_req_valid` appears in the 2nd rising edge after `rst_n` release (IDLE→REQ on 1st edge).
- Latency, with memory ready and a 1-cycle response (resp in the cycle after handshake), no redirect:
  - req handshake at cycle N, resp at N+1, `out_valid` at N+2.
  - Next request at N+3 if `out_ready` at N+2.
  - Peak throughput 1 instruction / 3 cycles.
- All state and outputs update on rising `clk`; outputs are pure functions of registered state, with no input→output combinational path.
- Reset mid-operation: any in-flight response is lost. The post-reset IDLE state ignores stray `imem_resp_valid`.

## Test plan
- Reset/boot: hold `rst_n`=0 3 cycles, release; ready=1, 1-cycle resp data 32'h0000_0013 -> req_addr=32'h8000_0000 at 2nd edge; out_valid with out_pc=32'h8000_0000, out_inst=32'h13; next req_addr=32'h8000_0004; fetch_cnt=1.
- Back-pressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc, out_inst stable, no new request; out_ready=1 -> one delivery, fetch_cnt increments once. Separately hold imem_req_ready=0 for 4 cycles -> req_valid and req_addr stable.
- Redirect in WAIT: handshake at 32'h8000_0008, redirect_pc=32'h8000_0100 next cycle, then resp 32'hDEAD_BEEF -> response discarded, out_valid never asserted for it, next req_addr=32'h8000_0100.
- Simultaneous events:
  - Redirect to 32'h8000_0203 coinciding with the req handshake -> response discarded, next req_addr=32'h8000_0200.
  - Redirect coinciding with out_ready in HOLD -> no delivery, fetch_cnt unchanged.
- Wrap: redirect to 32'hFFFF_FFFC, deliver -> next req_addr=32'h0000_0000. Force fetch_cnt near 32'hFFFF_FFFF via 2^32-delivery model check or preload -> wraps to 0.
- Async reset asserted in WAIT with a response arriving during/after reset -> outputs at reset values immediately (no clock edge needed); stray response ignored; boot sequence restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_25080199_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time,
// presents {pc, inst} downstream and takes redirects from execute.
module ysyx_25080199_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] inst_buf;
   logic        drop;
   logic [31:0] redir_pc;

   assign redir_pc       = {redirect_pc[31:2], 2'b00};
   assign imem_req_valid = (state == REQ);
   assign imem_req_addr  = pc;
   assign out_valid      = (state == HOLD);
   assign out_pc         = pc;
   assign out_inst       = inst_buf;

   // fetch FSM; drop marks an in-flight fetch made stale by a redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         inst_buf  <= 32'h0;
         drop      <= 1'b0;
         fetch_cnt <= 32'h0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (redirect_valid) pc <= redir_pc;
               if (imem_req_ready) begin
                  state <= WAIT;
                  drop  <= redirect_valid;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  pc   <= redir_pc;
                  drop <= 1'b1;
               end
               if (imem_resp_valid) begin
                  if (drop || redirect_valid) begin
                     drop  <= 1'b0;
                     state <= REQ;
                  end else begin
                     inst_buf <= imem_resp_data;
                     state    <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  pc    <= redir_pc;
                  state <= REQ;
               end else if (out_ready) begin
                  pc        <= pc + 32'd4;
                  fetch_cnt <= fetch_cnt + 32'd1;
                  state     <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
